// File: rtl/miriscv_div_seq.sv
// ---------------------------------------------------------------------------------------------
// miriscv_div_seq: sequential radix-2 restoring divider for the MIRISCV multiply/divide unit.
//
// Produces quotient and remainder for DIV/DIVU/REM/REMU with RISC-V M-extension semantics,
// including divide-by-zero and signed overflow. One quotient bit is resolved per clock;
// the pipeline is held through div_stall_req_o while the division iterates.
//
// Ports:
//   clk_i            clock, rising edge
//   arstn_i          asynchronous active-low reset
//   div_start_i      division requested for the instruction in execute
//   port_a_i         dividend
//   port_b_i         divisor
//   mdu_op_i         operation (MDU_DIV / MDU_DIVU / MDU_REM / MDU_REMU)
//   zero_i           divisor-is-zero flag, valid one cycle after the operands
//   kill_i           abort the current operation (flush)
//   keep_i           hold the finished result while the pipeline is stalled elsewhere
//   div_result_o     quotient
//   rem_result_o     remainder
//   div_stall_req_o  stall request, high while the division is in progress
// ---------------------------------------------------------------------------------------------

package miriscv_pkg;
    parameter int XLEN = 32;
endpackage

package miriscv_mdu_pkg;
    parameter int MDU_OP_W = 3;
    parameter logic [MDU_OP_W-1:0] MDU_DIV  = 3'd4;
    parameter logic [MDU_OP_W-1:0] MDU_DIVU = 3'd5;
    parameter logic [MDU_OP_W-1:0] MDU_REM  = 3'd6;
    parameter logic [MDU_OP_W-1:0] MDU_REMU = 3'd7;
endpackage

module miriscv_div_seq
    import miriscv_pkg::*;
    import miriscv_mdu_pkg::*;
(
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                div_start_i,
    input  logic [XLEN-1:0]     port_a_i,
    input  logic [XLEN-1:0]     port_b_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic                zero_i,
    input  logic                kill_i,
    input  logic                keep_i,
    output logic [XLEN-1:0]     div_result_o,
    output logic [XLEN-1:0]     rem_result_o,
    output logic                div_stall_req_o
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              first_q, first_d;    // first CALC cycle: zero_i is valid here
    logic [XLEN-1:0]   quo_q, quo_d;        // dividend magnitude shifting out, quotient in
    logic [XLEN-1:0]   part_rem_q, part_rem_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   a_orig_q, a_orig_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              signed_q, signed_d;
    logic [XLEN-1:0]   div_res_q, div_res_d;
    logic [XLEN-1:0]   rem_res_q, rem_res_d;

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN:0]     rem_sh;
    logic              trial_ge;
    logic [XLEN-1:0]   trial_sub;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quo_nxt;
    logic              neg_quo;
    logic              neg_rem;

    assign is_signed = (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM);
    assign a_neg     = is_signed & port_a_i[XLEN-1];
    assign b_neg     = is_signed & port_b_i[XLEN-1];

    // One restoring step. The shifted partial remainder can exceed XLEN bits, so the trial
    // compare uses XLEN+1 bits; when it succeeds the difference always fits in XLEN bits.
    assign rem_sh    = {part_rem_q, quo_q[XLEN-1]};
    assign trial_ge  = rem_sh >= {1'b0, divisor_q};
    assign trial_sub = rem_sh[XLEN-1:0] - divisor_q;
    assign rem_nxt   = trial_ge ? trial_sub : rem_sh[XLEN-1:0];
    assign quo_nxt   = {quo_q[XLEN-2:0], trial_ge};

    assign neg_quo   = signed_q & (sign_a_q ^ sign_b_q);
    assign neg_rem   = signed_q & sign_a_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        first_d         = first_q;
        quo_d           = quo_q;
        part_rem_d      = part_rem_q;
        divisor_d       = divisor_q;
        a_orig_d        = a_orig_q;
        sign_a_d        = sign_a_q;
        sign_b_d        = sign_b_q;
        signed_d        = signed_q;
        div_res_d       = div_res_q;
        rem_res_d       = rem_res_q;
        div_stall_req_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_stall_req_o = div_start_i;
                if (div_start_i) begin
                    state_d    = StCalc;
                    quo_d      = a_neg ? (~port_a_i + 1'b1) : port_a_i;
                    divisor_d  = b_neg ? (~port_b_i + 1'b1) : port_b_i;
                    a_orig_d   = port_a_i;
                    sign_a_d   = a_neg;
                    sign_b_d   = b_neg;
                    signed_d   = is_signed;
                    part_rem_d = '0;
                    cnt_d      = CntW'(XLEN);
                    first_d    = 1'b1;
                end
            end

            StCalc: begin
                div_stall_req_o = 1'b1;
                first_d         = 1'b0;
                if (first_q && zero_i) begin
                    // Division by zero: same result for signed and unsigned ops.
                    state_d   = StDone;
                    cnt_d     = '0;
                    div_res_d = '1;
                    rem_res_d = a_orig_q;
                end else begin
                    part_rem_d = rem_nxt;
                    quo_d      = quo_nxt;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        // Overflow (MIN / -1) falls out naturally: |MIN| negates to MIN.
                        state_d   = StDone;
                        div_res_d = neg_quo ? (~quo_nxt + 1'b1) : quo_nxt;
                        rem_res_d = neg_rem ? (~rem_nxt + 1'b1) : rem_nxt;
                    end
                end
            end

            StDone: begin
                if (!keep_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush wins over everything; finished results stay visible.
        if (kill_i) begin
            state_d         = StIdle;
            cnt_d           = '0;
            first_d         = 1'b0;
            div_res_d       = div_res_q;
            rem_res_d       = rem_res_q;
            div_stall_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            quo_q      <= '0;
            part_rem_q <= '0;
            divisor_q  <= '0;
            a_orig_q   <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            signed_q   <= 1'b0;
            div_res_q  <= '0;
            rem_res_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            quo_q      <= quo_d;
            part_rem_q <= part_rem_d;
            divisor_q  <= divisor_d;
            a_orig_q   <= a_orig_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            signed_q   <= signed_d;
            div_res_q  <= div_res_d;
            rem_res_q  <= rem_res_d;
        end
    end

    assign div_result_o = div_res_q;
    assign rem_result_o = rem_res_q;

endmodule

// File: tb/tb_miriscv_div_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_miriscv_div_seq: self-checking bench for miriscv_div_seq.
// Expected quotient/remainder/stall length are pushed to a scoreboard when a division is
// started and popped when the DUT drops its stall request.
// ---------------------------------------------------------------------------------------------

module tb_miriscv_div_seq;
    import miriscv_mdu_pkg::*;

    logic        clk;
    logic        arstn;
    logic        div_start;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [2:0]  mdu_op;
    logic        zero;
    logic        kill;
    logic        keep;
    logic [31:0] div_result;
    logic [31:0] rem_result;
    logic        stall;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    int          n_checks;
    int          n_pass;
    logic [31:0] last_quo;
    logic [31:0] last_rem;

    miriscv_div_seq u_dut (
        .clk_i           (clk),
        .arstn_i         (arstn),
        .div_start_i     (div_start),
        .port_a_i        (port_a),
        .port_b_i        (port_b),
        .mdu_op_i        (mdu_op),
        .zero_i          (zero),
        .kill_i          (kill),
        .keep_i          (keep),
        .div_result_o    (div_result),
        .rem_result_o    (rem_result),
        .div_stall_req_o (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic sgn;
        sgn = (op == MDU_DIV) || (op == MDU_REM);
        if (b == 32'd0) begin
            e.quo    = 32'hFFFF_FFFF;
            e.rem    = a;
            e.stalls = 2;
        end else begin
            e.stalls = 33;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.quo = 32'h8000_0000;
                e.rem = 32'd0;
            end else if (sgn) begin
                e.quo = 32'($signed(a) / $signed(b));
                e.rem = 32'($signed(a) % $signed(b));
            end else begin
                e.quo = a / b;
                e.rem = a % b;
            end
        end
        return e;
    endfunction

    // Start a division in the current (IDLE) cycle, count stall cycles, compare at DONE,
    // optionally hold DONE with keep for hold_n cycles, and return to IDLE with start low.
    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int hold_n);
        exp_t e;
        int   stalls;
        bit   done;
        sb.push_back(model(op, a, b));
        div_start = 1'b1;
        mdu_op    = op;
        port_a    = a;
        port_b    = b;
        zero      = (b == 32'd0);
        keep      = (hold_n > 0);
        stalls    = 0;
        done      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            // Scramble operands after the start edge; the result must not change.
            if (i == 2) begin
                port_a = ~a;
                port_b = 32'h1234_5678;
            end
        end
        check_eq({tag, " done"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            check_eq({tag, " sb"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, " stalls"}, 32'(stalls), 32'(e.stalls));
            check_eq({tag, " quo"}, div_result, e.quo);
            check_eq({tag, " rem"}, rem_result, e.rem);
            last_quo = e.quo;
            last_rem = e.rem;
            for (int k = 0; k < hold_n; k++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                check_eq({tag, " keep stall"}, 32'(stall), 32'd0);
                check_eq({tag, " keep quo"}, div_result, e.quo);
                check_eq({tag, " keep rem"}, rem_result, e.rem);
            end
        end
        @(posedge clk);
        #1;
        div_start = 1'b0;
        keep      = 1'b0;
        if (hold_n > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        arstn     = 1'b0;
        div_start = 1'b0;
        port_a    = '0;
        port_b    = '0;
        mdu_op    = MDU_DIVU;
        zero      = 1'b0;
        kill      = 1'b0;
        keep      = 1'b0;
        last_quo  = '0;
        last_rem  = '0;

        repeat (2) @(negedge clk);
        check_eq("reset quo", div_result, 32'd0);
        check_eq("reset rem", rem_result, 32'd0);
        check_eq("reset stall", 32'(stall), 32'd0);
        arstn = 1'b1;
        @(posedge clk);
        #1;

        run_div("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 0);
        run_div("remu 100/7", MDU_REMU, 32'd100, 32'd7, 0);
        run_div("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("rem -7/2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("div 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        run_div("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("divu 5/0", MDU_DIVU, 32'd5, 32'd0, 0);
        run_div("rem -9/0", MDU_REM, 32'hFFFF_FFF7, 32'd0, 0);
        run_div("divu big", MDU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0);

        // Kill in the 10th CALC cycle.
        div_start = 1'b1;
        mdu_op    = MDU_DIV;
        port_a    = 32'd50;
        port_b    = 32'd5;
        zero      = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        check_eq("kill stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        kill      = 1'b0;
        div_start = 1'b0;
        @(negedge clk);
        check_eq("kill idle stall", 32'(stall), 32'd0);
        check_eq("kill quo held", div_result, last_quo);
        check_eq("kill rem held", rem_result, last_rem);
        @(posedge clk);
        #1;
        run_div("divu 9/3 after kill", MDU_DIVU, 32'd9, 32'd3, 0);

        // Keep with start held high, then a new division.
        run_div("divu 9/3 keep", MDU_DIVU, 32'd9, 32'd3, 5);
        run_div("divu 20/6", MDU_DIVU, 32'd20, 32'd6, 0);

        // Asynchronous reset in the middle of CALC.
        div_start = 1'b1;
        mdu_op    = MDU_DIVU;
        port_a    = 32'd100;
        port_b    = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        arstn     = 1'b0;
        div_start = 1'b0;
        #1;
        check_eq("arst quo", div_result, 32'd0);
        check_eq("arst rem", rem_result, 32'd0);
        check_eq("arst stall", 32'(stall), 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst idle stall", 32'(stall), 32'd0);
        run_div("divu after arst", MDU_DIVU, 32'd1000, 32'd33, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/miriscv_div_seq.md
# miriscv_div_seq

Sequential radix-2 restoring divider for the MIRISCV multiply/divide unit. It sits directly downstream of the MDU front end: it accepts a division request with operands from the execute stage, and holds the pipeline via a stall request while it iterates. It returns quotient and remainder for DIV, DIVU, REM and REMU with RISC-V M-extension semantics, including divide-by-zero and signed overflow. It also supports pipeline kill and result-keep.

## Interface
- No local parameters.
- XLEN, 32: operand width, imported from miriscv_pkg.
- MDU_OP_W, package value: opcode width. Imported together with the MDU_DIV, MDU_DIVU, MDU_REM and MDU_REMU encodings from miriscv_mdu_pkg.
- clk_i  in  1  single clock; all state updates on the rising edge.
- arstn_i  in  1  asynchronous, active-low reset.
- div_start_i  in  1  division requested for the instruction in execute; held high while that instruction is held.
- port_a_i  in  XLEN  dividend; stable while div_start_i is high.
- port_b_i  in  XLEN  divisor; stable while div_start_i is high.
- mdu_op_i  in  MDU_OP_W  operation; only the four division encodings are meaningful.
- zero_i  in  1  divisor-is-zero flag, registered one cycle after the operands are presented.
- kill_i  in  1  abort the current operation (flush).
- keep_i  in  1  hold the finished result and block re-execution while the pipeline is stalled elsewhere.
- div_result_o  out  XLEN  quotient.
- rem_result_o  out  XLEN  remainder.
- div_stall_req_o  out  1  stall the pipeline; high while the division is in progress.

## Operation
- **States**
  - IDLE: no operation in progress.
  - CALC: iterating.
  - DONE: result valid.
  - Reset state is IDLE.
- **Reset values**: iteration counter 0, all datapath registers 0. div_result_o = 0, rem_result_o = 0, div_stall_req_o = 0.
- **Signed-operation definition**: signed = (mdu_op_i is MDU_DIV or MDU_REM).
- **IDLE to CALC**: taken when div_start_i=1 and kill_i=0. At that edge:
  - Latch |a| and |b| (magnitude only if signed and the MSB is set).
  - Latch the original a, sign_a and sign_b.
  - Latch the op class: quotient or remainder, signed or unsigned.
  - Clear the partial remainder. Load the counter with XLEN.
- **CALC, first cycle**: zero_i is sampled. If zero_i=1, go to DONE with quotient = all ones and remainder = original a, for all four ops.
- **CALC, each iteration**:
  - Shift {rem, quo} left by 1.
  - Trial subtract divisor from rem.
  - If the result is non-negative, keep it and set quo[0]=1. Otherwise restore.
  - Decrement the counter. When the counter reaches 1, transition to DONE.
- **Result write on entry to DONE**:
  - Quotient is negated if signed and sign_a≠sign_b.
  - Remainder is negated if signed and sign_a=1.
  - Both values are written to the output registers.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF) needs no special case: the result is quotient 0x80000000, remainder 0.
- **Leaving DONE**:
  - keep_i=1: remain in DONE. Outputs are held and div_start_i is ignored.
  - keep_i=0: go to IDLE at the next edge.
  - div_start_i high during the DONE cycle never starts a new operation.
- **kill_i=1 in any state**: next state is IDLE; the counter is cleared and the output registers are unchanged. kill_i has priority over div_start_i, zero_i and keep_i.
- **Output holding**: outputs hold their last written values in IDLE and DONE. They are updated only on entry to DONE.

## Timing
- **div_stall_req_o** is combinational:
  - = (IDLE and div_start_i) or CALC, gated low whenever kill_i=1.
  - Always 0 in DONE.
- **Normal division**:
  - Start in cycle 0 (IDLE with div_start_i=1); stall is high in cycles 0 through XLEN.
  - DONE is reached in cycle XLEN+1, with stall=0 and valid outputs.
  - Total stall is XLEN+1 cycles (33 for XLEN=32).
- **Divide by zero**: stall is high in cycles 0 and 1; DONE in cycle 2.
- **Back-to-back divisions**: DONE for instruction A in cycle N, IDLE in cycle N+1. Instruction B's start is accepted in cycle N+1, with stall high from N+1.
- **Reset mid-operation**: asynchronous return to IDLE with all outputs 0. The stall drops immediately.
- **Operand changes**: operand changes after the start edge have no effect on the result.

## Test plan
- DIVU 100/7: stall high 33 cycles, then stall=0, div_result_o=14. REMU 100/7 gives rem_result_o=2.
- DIV -7/2 gives quotient 0xFFFFFFFD (-3). REM -7/2 gives remainder 0xFFFFFFFF (-1). DIV 7/-2 gives 0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0. DIVU 5/0 gives quotient 0xFFFFFFFF, remainder 5, with stall exactly 2 cycles.
- Start DIV 50/5, assert kill_i in the 10th CALC cycle: stall=0 in that cycle, IDLE next, outputs unchanged. A new DIVU 9/3 started afterwards gives quotient 3.
- DIVU 9/3 reaches DONE while keep_i=1 and div_start_i=1 for 5 cycles: stall stays 0, outputs stay 3/0, no restart. Drop keep_i, then start 20/6 next cycle: quotient 3, remainder 2.
- Assert arstn_i low during CALC: all outputs 0 immediately, state IDLE, stall 0.
